bm_if_collapse_param: RTL
=========================

Name: bm_if_collapse_param

Overview:
Parametrised multi-channel successor to the single-lane if/case-collapse microbenchmark, used as a synthesis stress block for if-chain and case-statement collapsing across replicated lanes.
- Each of CHANNELS lanes has a priority clear/conditional-load output register (out0/out1).
- Each lane also has a case-decoded register pair feeding a configurable-depth pipeline (out2), tagged by a valid strobe.
- A saturating counter tracks load activity across all lanes.

Parameters:
WIDTH, 2, operand bit width per lane (>=2)
CHANNELS, 4, number of independent lanes (>=1)
DEPTH, 2, register stages from the decode pair to out2 (>=1)
CNT_W, 8, width of the saturating update counter (>=1)

Ports:
clock  input  1  rising-edge clock
reset  input  1  asynchronous, active-high reset
in_valid  input  1  qualifies a_in/b_in/en for the current cycle
a_in  input  CHANNELS*WIDTH  lane i operand A, bits [i*WIDTH +: WIDTH]
b_in  input  CHANNELS*WIDTH  lane i operand B
clr  input  CHANNELS  per-lane clear, highest priority
en  input  CHANNELS  per-lane load enable
out0  output  CHANNELS*WIDTH  per-lane registered a&b
out1  output  CHANNELS  per-lane registered OR-reduce of a&b
out2  output  CHANNELS*WIDTH  per-lane pipelined decode result
out2_valid  output  1  marks out2 carrying the result of a valid input
upd_count  output  CNT_W  saturating count of cycles with at least one lane load

Behaviour:
- Reset (asynchronous, takes effect immediately, any cycle including mid-pipeline):
  - Clears out0, out1, out2, out2_valid, upd_count.
  - Clears the internal r1/r2 decode registers, all pipeline stages and all valid stages.
- Lane i load path, evaluated at each rising edge, in priority order:
  - clr[i]=1: out0 lane <= 0 and out1[i] <= 0. in_valid is not required, and clr wins over en.
  - else in_valid=1 and en[i]=1: out0 lane <= a&b; out1[i] <= |(a&b).
  - else: hold.
- Lane i decode path, evaluated at each rising edge when in_valid=1 (hold otherwise; clr and en have no effect):
  - a=0 and b!=1: r2 <= all ones.
  - a=0 and b=1: no change.
  - a!=0: r1 <= ~a. For WIDTH=2 this gives 01->10, 10->01, 11->00.
- Pipeline:
  - Stage 1 <= r1 & r2 every cycle, unconditionally. Stages 2..DEPTH shift every cycle.
  - out2 = stage DEPTH.
  - An input sampled at edge k updates r at edge k and appears on out2 after edge k+DEPTH.
  - When r holds, out2 settles to a constant.
- Valid tracking:
  - A shift register of length DEPTH+1 is loaded with in_valid at edge k.
  - out2_valid goes high after edge k+DEPTH for exactly one cycle per valid input.
  - Back-to-back valid inputs give back-to-back out2_valid.
- Counter:
  - upd_count increments by 1 at each edge where in_valid=1 and some lane has en[i]=1 and clr[i]=0.
  - The increment is 1 regardless of how many lanes load.
  - Saturates at 2^CNT_W-1 and does not wrap.
- Lanes are fully independent; simultaneous clr on one lane and load on another both take effect.

Test Plan:
- WIDTH=2, CHANNELS=2: lane0 a=10, b=11, en=01, clr=00, in_valid=1 for one edge -> out0[1:0]=10, out1[0]=1, lane1 unchanged (0), upd_count=1.
- After the load above: clr=01, en=01, in_valid=0 -> out0[1:0]=00, out1[0]=0, upd_count stays 1. Repeat with en=01, in_valid=1, clr=01 -> lane cleared, upd_count stays 1.
- DEPTH=2, lane0 decode sequence:
  - edge k1: a=00, b=00, valid -> r2=11.
  - edge k2: a=01, valid -> r1=10.
  - After edge k2+2: out2[1:0]=10 and out2_valid=1 for one cycle.
  - Then a=00, b=01, valid -> r unchanged, out2 stays 10.
- en=11 with in_valid=0 for 5 cycles -> out0, out1, r and upd_count unchanged; out2_valid stays 0.
- CNT_W=3: 9 consecutive loading cycles -> upd_count reads 1..7, then holds at 7.
- Assert reset asynchronously between edges while out2_valid is in flight -> all outputs read 0 before the next edge, and no out2_valid pulse follows after release.

Source files
------------

// File: rtl/bm_if_collapse_param.sv
// Multi-lane if/case-collapse stress block.
// Each lane has a priority clear/load output register pair (out0/out1) and a
// case-decoded register pair (r1/r2) whose AND feeds a DEPTH-stage pipeline
// (out2). A valid shift register tags out2, and a saturating counter records
// the cycles in which at least one lane loaded.
module bm_if_collapse_param #(
    parameter int unsigned WIDTH    = 2,
    parameter int unsigned CHANNELS = 4,
    parameter int unsigned DEPTH    = 2,
    parameter int unsigned CNT_W    = 8
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic                      in_valid,
    input  logic [CHANNELS*WIDTH-1:0] a_in,
    input  logic [CHANNELS*WIDTH-1:0] b_in,
    input  logic [CHANNELS-1:0]       clr,
    input  logic [CHANNELS-1:0]       en,
    output logic [CHANNELS*WIDTH-1:0] out0,
    output logic [CHANNELS-1:0]       out1,
    output logic [CHANNELS*WIDTH-1:0] out2,
    output logic                      out2_valid,
    output logic [CNT_W-1:0]          upd_count
);

    localparam int unsigned BUS_W = CHANNELS * WIDTH;

    logic [BUS_W-1:0]    out0_q, out0_d;
    logic [CHANNELS-1:0] out1_q, out1_d;
    logic [BUS_W-1:0]    r1_q, r1_d;
    logic [BUS_W-1:0]    r2_q, r2_d;
    logic [BUS_W-1:0]    pipe_q [DEPTH];
    logic [DEPTH:0]      vld_q;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                load_any;

    // A cycle counts as an update when any lane loads (valid, enabled, not cleared).
    assign load_any = in_valid & (|(en & ~clr));

    // Load path: clear beats load, load needs in_valid, otherwise hold.
    always_comb begin
        // NOTE: every variable gets its hold value first so no path leaves it unassigned (no latch).
        out0_d = out0_q;
        out1_d = out1_q;
        for (int i = 0; i < CHANNELS; i++) begin
            if (clr[i]) begin
                out0_d[i*WIDTH +: WIDTH] = '0;
                out1_d[i]                = 1'b0;
            end else if (in_valid && en[i]) begin
                out0_d[i*WIDTH +: WIDTH] = a_in[i*WIDTH +: WIDTH] & b_in[i*WIDTH +: WIDTH];
                out1_d[i]                = |(a_in[i*WIDTH +: WIDTH] & b_in[i*WIDTH +: WIDTH]);
            end
        end
    end

    // Decode path: only valid cycles update r1/r2; clr and en are ignored here.
    always_comb begin
        r1_d = r1_q;
        r2_d = r2_q;
        if (in_valid) begin
            for (int i = 0; i < CHANNELS; i++) begin
                if (a_in[i*WIDTH +: WIDTH] != '0) begin
                    r1_d[i*WIDTH +: WIDTH] = ~a_in[i*WIDTH +: WIDTH];
                end else if (b_in[i*WIDTH +: WIDTH] != WIDTH'(1)) begin
                    r2_d[i*WIDTH +: WIDTH] = '1;
                end
            end
        end
    end

    // Saturating update counter: stops at all ones instead of wrapping.
    always_comb begin
        cnt_d = cnt_q;
        if (load_any && (cnt_q != '1)) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    // Lane output, decode and counter registers.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            out0_q <= '0;
            out1_q <= '0;
            r1_q   <= '0;
            r2_q   <= '0;
            cnt_q  <= '0;
        end else begin
            // NOTE: state registers use non-blocking assignment so all flops sample pre-edge values.
            out0_q <= out0_d;
            out1_q <= out1_d;
            r1_q   <= r1_d;
            r2_q   <= r2_d;
            cnt_q  <= cnt_d;
        end
    end

    // Data pipeline: stage 0 captures r1&r2 every cycle, later stages shift.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            // NOTE: pipeline stages are reset so out2 reads zero the moment reset asserts.
            for (int j = 0; j < DEPTH; j++) begin
                pipe_q[j] <= '0;
            end
        end else begin
            pipe_q[0] <= r1_q & r2_q;
            for (int j = 1; j < DEPTH; j++) begin
                pipe_q[j] <= pipe_q[j-1];
            end
        end
    end

    // Valid tag: in_valid enters bit 0 and reaches bit DEPTH alongside its data.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            vld_q <= '0;
        end else begin
            vld_q <= {vld_q[DEPTH-1:0], in_valid};
        end
    end

    assign out0       = out0_q;
    assign out1       = out1_q;
    assign out2       = pipe_q[DEPTH-1];
    assign out2_valid = vld_q[DEPTH];
    assign upd_count  = cnt_q;

endmodule
